// File: rtl/modulo_estoque_rolhas.sv
// Cork-stock controller: live count, hysteresis low-stock flag and
// a dispenser refill FSM that tops the stock up by a bounded batch.
module modulo_estoque_rolhas #(
    parameter int WIDTH        = 5,
    parameter int CAPACITY     = 20,
    parameter int MIN_LEVEL    = 5,
    parameter int HYST         = 2,
    parameter int REFILL_BATCH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             auto_en,
    input  logic             consume,
    input  logic             refill_valid,
    output logic [WIDTH-1:0] stock,
    output logic             min_signal,
    output logic             empty,
    output logic             full,
    output logic             refill_req,
    output logic             consume_ok,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] CAP_W   = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0] LOW_W   = WIDTH'(MIN_LEVEL);
    localparam logic [WIDTH-1:0] HIGH_W  = WIDTH'(MIN_LEVEL + HYST);
    localparam logic [WIDTH-1:0] BATCH_W = WIDTH'(REFILL_BATCH);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stock_q, stock_d;
    logic [WIDTH-1:0] batch_q, batch_d;
    logic             min_q, min_d;
    logic             cok_q, cok_d;
    logic             uf_q, uf_d;
    logic             cons_acc;
    logic             ref_acc;

    always_comb begin
        cons_acc = consume && (stock_q != '0);
        ref_acc  = (state_q == FILL) && refill_valid &&
                   (stock_q < CAP_W) && (batch_q < BATCH_W);

        stock_d = stock_q;
        batch_d = batch_q;
        state_d = state_q;
        min_d   = min_q;
        cok_d   = cons_acc;
        uf_d    = uf_q | (consume && (stock_q == '0));

        if (cons_acc && !ref_acc) begin
            stock_d = stock_q - ONE;
        end else if (ref_acc && !cons_acc) begin
            stock_d = stock_q + ONE;
        end

        if (ref_acc) begin
            batch_d = batch_q + ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (auto_en && min_q) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!auto_en) begin
                    state_d = IDLE;
                end else if (ref_acc &&
                             (batch_d == BATCH_W || stock_d == CAP_W)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Batch count restarts for every refill episode.
        if (state_d == IDLE) begin
            batch_d = '0;
        end

        if (stock_d <= LOW_W) begin
            min_d = 1'b1;
        end else if (stock_d > HIGH_W) begin
            min_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stock_q <= '0;
            batch_q <= '0;
            min_q   <= 1'b1;
            cok_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stock_q <= stock_d;
            batch_q <= batch_d;
            min_q   <= min_d;
            cok_q   <= cok_d;
            uf_q    <= uf_d;
        end
    end

    assign stock      = stock_q;
    assign min_signal = min_q;
    assign empty      = (stock_q == '0);
    assign full       = (stock_q == CAP_W);
    assign refill_req = (state_q == FILL);
    assign consume_ok = cok_q;
    assign underflow  = uf_q;

endmodule

// File: tb/tb_modulo_estoque_rolhas.sv
// Directed bench for the cork-stock controller: vector table for short
// cases, loops for the long fill/consume runs.
module tb_modulo_estoque_rolhas;

    logic       clk = 1'b0;
    logic       reset;
    logic       auto_en;
    logic       consume;
    logic       refill_valid;
    logic [4:0] stock;
    logic       min_signal;
    logic       empty;
    logic       full;
    logic       refill_req;
    logic       consume_ok;
    logic       underflow;

    int n_cmp = 0;
    int n_bad = 0;

    modulo_estoque_rolhas dut (
        .clk          (clk),
        .reset        (reset),
        .auto_en      (auto_en),
        .consume      (consume),
        .refill_valid (refill_valid),
        .stock        (stock),
        .min_signal   (min_signal),
        .empty        (empty),
        .full         (full),
        .refill_req   (refill_req),
        .consume_ok   (consume_ok),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, a, c, v;
        int   s;
        logic mn, em, fu, rq, ok, uf;
    } vec_t;

    vec_t tv[19];

    task automatic chk(input string n, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic a,
                        input logic c, input logic v);
        reset        = r;
        auto_en      = a;
        consume      = c;
        refill_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string t, input int s,
                             input logic mn, input logic em,
                             input logic fu, input logic rq,
                             input logic ok, input logic uf);
        chk({t, "/stock"}, int'(stock), s);
        chk({t, "/min"}, int'(min_signal), int'(mn));
        chk({t, "/empty"}, int'(empty), int'(em));
        chk({t, "/full"}, int'(full), int'(fu));
        chk({t, "/req"}, int'(refill_req), int'(rq));
        chk({t, "/ok"}, int'(consume_ok), int'(ok));
        chk({t, "/uf"}, int'(underflow), int'(uf));
    endtask

    initial begin
        int s;
        reset        = 1'b1;
        auto_en      = 1'b0;
        consume      = 1'b0;
        refill_valid = 1'b0;

        // r a c v | stock min empty full req ok uf
        tv[0]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1};
        tv[2]  = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1};
        tv[3]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
        tv[4]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tv[5]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tv[6]  = '{0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0};
        tv[7]  = '{0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0};
        tv[8]  = '{0, 1, 0, 1, 2, 1, 0, 0, 1, 0, 0};
        tv[9]  = '{0, 1, 0, 1, 3, 1, 0, 0, 1, 0, 0};
        tv[10] = '{0, 1, 0, 1, 4, 1, 0, 0, 1, 0, 0};
        tv[11] = '{0, 1, 1, 1, 4, 1, 0, 0, 1, 1, 0};
        tv[12] = '{0, 1, 1, 1, 4, 1, 0, 0, 1, 1, 0};
        tv[13] = '{0, 1, 1, 1, 4, 1, 0, 0, 1, 1, 0};
        tv[14] = '{0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0};
        tv[15] = '{0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0};
        tv[16] = '{0, 1, 0, 1, 4, 1, 0, 0, 1, 0, 0};
        tv[17] = '{0, 1, 0, 1, 5, 1, 0, 0, 1, 0, 0};
        tv[18] = '{1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            step(tv[i].r, tv[i].a, tv[i].c, tv[i].v);
            check_out($sformatf("vec%0d", i), tv[i].s, tv[i].mn,
                      tv[i].em, tv[i].fu, tv[i].rq, tv[i].ok, tv[i].uf);
        end

        // Reset then auto-refill from empty: 15-cork batch limit.
        step(1, 1, 0, 1);
        check_out("fillA_rst", 0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1);
        check_out("fillA_enter", 0, 1, 1, 0, 1, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 1, 0, 1);
            check_out($sformatf("fillA_%0d", i), i, (i <= 7),
                      1'b0, 1'b0, (i < 15), 1'b0, 1'b0);
        end
        step(0, 1, 0, 1);
        check_out("fillA_hold", 15, 0, 0, 0, 0, 0, 0);

        // Consume 15 -> 5: min held low at 7 and 6, rises at 5.
        for (int k = 14; k >= 5; k--) begin
            step(0, 1, 1, 0);
            check_out($sformatf("cons_%0d", k), k, (k <= 5),
                      1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Refill from 5: capacity and batch limit hit on the same cork.
        step(0, 1, 0, 1);
        check_out("fillB_enter", 5, 1, 0, 0, 1, 0, 0);
        for (int j = 1; j <= 15; j++) begin
            s = 5 + j;
            step(0, 1, 0, 1);
            check_out($sformatf("fillB_%0d", j), s, (s <= 7),
                      1'b0, (s == 20), (j < 15), 1'b0, 1'b0);
        end
        step(0, 1, 0, 1);
        check_out("fillB_hold", 20, 0, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
